// File: rtl/idx_buf_sched_pkg.sv
// idx_sched_pkg: shared sizing helpers for the channel-index buffer write scheduler
package idx_sched_pkg;

    localparam int BUFFER_SIZE_DFLT = 8;
    localparam int COUNT_W          = BUFFER_SIZE_DFLT + 1;
    localparam int FULL_CNT         = 1 << BUFFER_SIZE_DFLT;

    // One extra count bit keeps "full" distinct from an empty group.
    function automatic int count_w(input int buffer_size);
        return buffer_size + 1;
    endfunction

    function automatic int full_cnt(input int buffer_size);
        return 1 << buffer_size;
    endfunction

endpackage

// File: rtl/idx_buf_sched_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first requesting lane at or after ptr_i
//   req_i   lane request vector
//   ptr_i   lane with highest priority this cycle
//   grant_o one-hot grant (zero when no request)
//   idx_o   encoded index of the granted lane
module rr_arbiter #(
    parameter int N_REQ = 2,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IW-1:0]    idx_o
);

    logic [IW-1:0] s;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        s       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            s = IW'((int'(ptr_i) + k) % N_REQ);
            if (req_i[s]) begin
                grant_o    = '0;
                grant_o[s] = 1'b1;
                idx_o      = s;
            end
        end
    end

endmodule

// File: rtl/idx_buf_sched.sv
// idx_buf_sched: round-robin write scheduler for the outlier channel-index buffer
//   clk, rstn                      clock, async active-low reset
//   req_valid/ready/chidx/group    per-lane write requests
//   clr_valid, clr_group           clear one group's fill count (blocks grants)
//   cnt_group, cnt_value           fill-count readback
//   ovf_clr, ovf_flag, ovf_group   sticky overflow flag and first dropped group
//   buf_valid/addr/counter/chidx   registered buffer write port
module idx_buf_sched
    import idx_sched_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int BUFFER_SIZE = 8,
    parameter int N_REQ       = 2
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [N_REQ-1:0]                  req_valid,
    output logic [N_REQ-1:0]                  req_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0]       req_chidx,
    input  logic [N_REQ*BUFFER_SIZE-1:0]      req_group,
    input  logic                              clr_valid,
    input  logic [BUFFER_SIZE-1:0]            clr_group,
    input  logic [BUFFER_SIZE-1:0]            cnt_group,
    output logic [BUFFER_SIZE:0]              cnt_value,
    input  logic                              ovf_clr,
    output logic                              ovf_flag,
    output logic [BUFFER_SIZE-1:0]            ovf_group,
    output logic                              buf_valid,
    output logic [BUFFER_SIZE-1:0]            buf_addr,
    output logic [7:0]                        buf_counter,
    output logic [DATA_WIDTH-1:0]             buf_chidx
);

    localparam int CW   = count_w(BUFFER_SIZE);
    localparam int FULL = full_cnt(BUFFER_SIZE);
    localparam int IW   = $clog2(N_REQ);
    localparam int NG   = 1 << BUFFER_SIZE;

    logic [CW-1:0]          cnt_q [NG];
    logic [IW-1:0]          ptr_q, ptr_d, gidx;
    logic [N_REQ-1:0]       grant;
    logic                   hs, full;
    logic [BUFFER_SIZE-1:0] sel_group;
    logic [DATA_WIDTH-1:0]  sel_chidx;
    logic [CW-1:0]          sel_cnt;
    logic                   buf_valid_q, ovf_flag_q;
    logic [BUFFER_SIZE-1:0] buf_addr_q, ovf_group_q;
    logic [7:0]             buf_counter_q;
    logic [DATA_WIDTH-1:0]  buf_chidx_q;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (gidx)
    );

    assign req_ready = grant & {N_REQ{~clr_valid}};
    assign hs        = |req_ready;
    assign sel_group = req_group[gidx*BUFFER_SIZE +: BUFFER_SIZE];
    assign sel_chidx = req_chidx[gidx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_cnt   = cnt_q[sel_group];
    assign full      = sel_cnt == CW'(FULL);
    assign ptr_d     = hs ? ((gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1) : ptr_q;
    assign cnt_value = cnt_q[cnt_group];

    assign buf_valid   = buf_valid_q;
    assign buf_addr    = buf_addr_q;
    assign buf_counter = buf_counter_q;
    assign buf_chidx   = buf_chidx_q;
    assign ovf_flag    = ovf_flag_q;
    assign ovf_group   = ovf_group_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NG; i++) cnt_q[i] <= '0;
            ptr_q         <= '0;
            buf_valid_q   <= 1'b0;
            buf_addr_q    <= '0;
            buf_counter_q <= '0;
            buf_chidx_q   <= '0;
            ovf_flag_q    <= 1'b0;
            ovf_group_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            buf_valid_q <= hs & ~full;
            if (hs && !full) begin
                buf_addr_q       <= sel_group;
                buf_counter_q    <= 8'(sel_cnt);
                buf_chidx_q      <= sel_chidx;
                cnt_q[sel_group] <= sel_cnt + 1'b1;
            end
            // A clear never coincides with a grant, so the two count writes cannot collide.
            if (clr_valid) cnt_q[clr_group] <= '0;
            // A drop outranks a same-cycle ovf_clr and re-captures the group.
            if (hs && full) begin
                ovf_flag_q <= 1'b1;
                if (!ovf_flag_q || ovf_clr) ovf_group_q <= sel_group;
            end else if (ovf_clr) begin
                ovf_flag_q  <= 1'b0;
                ovf_group_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_idx_buf_sched.sv
// tb_idx_buf_sched: scoreboard bench with a queue-based reference model
module tb_idx_buf_sched;

    localparam int DW   = 16;
    localparam int BS   = 3;
    localparam int N    = 2;
    localparam int FULL = 1 << BS;
    localparam int NG   = 1 << BS;

    logic            clk, rstn;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*DW-1:0] req_chidx;
    logic [N*BS-1:0] req_group;
    logic            clr_valid, ovf_clr, ovf_flag, buf_valid;
    logic [BS-1:0]   clr_group, cnt_group, ovf_group, buf_addr;
    logic [BS:0]     cnt_value;
    logic [7:0]      buf_counter;
    logic [DW-1:0]   buf_chidx;

    idx_buf_sched #(.DATA_WIDTH(DW), .BUFFER_SIZE(BS), .N_REQ(N)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_chidx(req_chidx), .req_group(req_group),
        .clr_valid(clr_valid), .clr_group(clr_group),
        .cnt_group(cnt_group), .cnt_value(cnt_value),
        .ovf_clr(ovf_clr), .ovf_flag(ovf_flag), .ovf_group(ovf_group),
        .buf_valid(buf_valid), .buf_addr(buf_addr), .buf_counter(buf_counter), .buf_chidx(buf_chidx)
    );

    typedef struct {
        bit v;
        int addr;
        int ctr;
        int chidx;
        bit of;
        int og;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   m_cnt[NG];
    int   m_ptr, m_og, last_g;
    bit   m_of;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_ptr  = 0;
        m_of   = 0;
        m_og   = 0;
        last_g = -1;
    endtask

    // Entered at posedge+1; returns at the next posedge+1.
    task automatic step(input bit v0, input bit v1, input int g0, input int g1,
                        input int d0, input int d1, input bit clr, input int cg,
                        input bit oc, input int rg);
        int   g, grp;
        bit   hs;
        exp_t e;
        req_valid = {v1, v0};
        req_group = {BS'(g1), BS'(g0)};
        req_chidx = {DW'(d1), DW'(d0)};
        clr_valid = clr;
        clr_group = BS'(cg);
        ovf_clr   = oc;
        cnt_group = BS'(rg);
        #2;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (g < 0 && (i == 1 ? v1 : v0)) g = i;
        end
        hs = (g >= 0) && !clr;
        chk("req_ready", 32'(req_ready), hs ? (32'd1 << g) : 32'd0);
        chk("cnt_value", 32'(cnt_value), m_cnt[rg]);
        e   = '{default: 0};
        grp = 0;
        if (hs) begin
            grp = (g == 1) ? g1 : g0;
            if (m_cnt[grp] < FULL) begin
                e.v     = 1;
                e.addr  = grp;
                e.ctr   = m_cnt[grp];
                e.chidx = (g == 1) ? d1 : d0;
                m_cnt[grp]++;
                if (oc) begin m_of = 0; m_og = 0; end
            end else begin
                if (!m_of || oc) m_og = grp;
                m_of = 1;
            end
            m_ptr = (g + 1) % N;
        end else if (oc) begin
            m_of = 0;
            m_og = 0;
        end
        if (clr) m_cnt[cg] = 0;
        e.of = m_of;
        e.og = m_og;
        q.push_back(e);
        last_g = hs ? g : -1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        int grps[3];
        grps = '{0, 5, 7};
        rstn = 1'b0;
        q.delete();
        model_reset();
        #1;
        chk("rst_buf_valid", 32'(buf_valid), 0);
        chk("rst_ovf_flag", 32'(ovf_flag), 0);
        chk("rst_ovf_group", 32'(ovf_group), 0);
        chk("rst_buf_addr", 32'(buf_addr), 0);
        chk("rst_buf_counter", 32'(buf_counter), 0);
        chk("rst_buf_chidx", 32'(buf_chidx), 0);
        foreach (grps[i]) begin
            cnt_group = BS'(grps[i]);
            #1;
            chk("rst_cnt_value", 32'(cnt_value), 0);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Monitor: one expectation per cycle, compared after the edge it describes.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("buf_valid", 32'(buf_valid), 32'(e.v));
                if (e.v) begin
                    chk("buf_addr", 32'(buf_addr), e.addr);
                    chk("buf_counter", 32'(buf_counter), e.ctr);
                    chk("buf_chidx", 32'(buf_chidx), e.chidx);
                end
                chk("ovf_flag", 32'(ovf_flag), 32'(e.of));
                chk("ovf_group", 32'(ovf_group), e.og);
            end
        end
    end

    initial begin
        int na, nb;
        rstn = 1'b1;
        req_valid = '0; req_chidx = '0; req_group = '0;
        clr_valid = 0; clr_group = '0; cnt_group = '0; ovf_clr = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        // single lane, consecutive writes to group 5
        step(1, 0, 5, 0, 'h0011, 0, 0, 0, 0, 5);
        step(1, 0, 5, 0, 'h0022, 0, 0, 0, 0, 5);
        step(1, 0, 5, 0, 'h0033, 0, 0, 0, 0, 5);
        idle(2);
        // mid-stream reset with lanes still requesting
        step(1, 1, 5, 5, 'h0044, 'h0055, 0, 0, 0, 5);
        do_reset();
        // contention on group 7 from reset
        na = 0; nb = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 7, 7, 'hA000 + na, 'hB000 + nb, 0, 0, 0, 7);
            if (last_g == 0) na++;
            else if (last_g == 1) nb++;
        end
        // clear blocks grants; next write to group 7 restarts at slot 0
        step(1, 1, 7, 7, 'hA000 + na, 'hB000 + nb, 1, 7, 0, 7);
        step(1, 1, 7, 7, 'hA000 + na, 'hB000 + nb, 0, 0, 0, 7);
        idle(1);
        // overflow group 1
        for (int i = 0; i <= FULL; i++) step(1, 0, 1, 0, 'h100 + i, 0, 0, 0, 0, 1);
        idle(2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);
        // group 2 full, flag set by group 1, then drop on group 2 with ovf_clr
        for (int i = 0; i < FULL; i++) step(0, 1, 0, 2, 0, 'h200 + i, 0, 0, 0, 2);
        step(1, 0, 1, 0, 'h1FF, 0, 0, 0, 0, 1);
        step(0, 1, 0, 2, 0, 'h2FF, 0, 0, 1, 2);
        idle(2);
        // randomized traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom), 1'($urandom), int'($urandom_range(0, NG - 1)), int'($urandom_range(0, NG - 1)),
                 int'($urandom_range(0, 'hFFFF)), int'($urandom_range(0, 'hFFFF)),
                 ($urandom_range(0, 7) == 0), int'($urandom_range(0, NG - 1)),
                 ($urandom_range(0, 15) == 0), int'($urandom_range(0, NG - 1)));
        idle(3);
        @(posedge clk);
        #3;
        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
